bcd_countdown_editor: RTL and testbench

Parametrised BCD time-field editor with a countdown run mode, the next generation of the six-digit cursor/up/down setting blocks that feed the clock/timer display path. It holds `NFIELDS` two-digit BCD fields (most significant field first on the display), lets the user move a digit cursor and edit digits with range-correct wrap, and then counts the stored value down to zero on an external 1 Hz tick. When zero is reached it raises an expiry flag.

---
 rtl/bcd_countdown_editor_pkg.sv | 34 +++
 rtl/bcd_countdown_editor_if.sv | 33 +++
 rtl/bcd_countdown_editor_field.sv | 78 +++++++
 rtl/bcd_countdown_editor.sv | 127 ++++++++++++
 tb/tb_bcd_countdown_editor.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/bcd_countdown_editor_pkg.sv
`default_nettype none
// ============================================================================
//  Package : bcd_time_pkg
//  Shared constants and BCD helpers for the countdown editor.
//  Revision: 1.0 - initial release
// ============================================================================
package bcd_time_pkg;

  // Maximum value of every field except the top one (seconds, minutes).
  localparam int SUB_MAX = 59;

  // Two run modes of the editor.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mode_t;

  // Maximum value of field k; the top field has its own limit.
  function automatic int field_max(input int k, input int nfields, input int top_max);
    return (k == nfields - 1) ? top_max : SUB_MAX;
  endfunction

  // Increment a BCD digit, wrapping past lim back to 0.
  function automatic logic [3:0] bcd_inc(input logic [3:0] d, input logic [3:0] lim);
    return (d >= lim) ? 4'd0 : d + 4'd1;
  endfunction

  // Decrement a BCD digit, wrapping below 0 up to lim.
  function automatic logic [3:0] bcd_dec(input logic [3:0] d, input logic [3:0] lim);
    return (d == 4'd0) ? lim : d - 4'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_countdown_editor_if.sv
`default_nettype none
// ============================================================================
//  Interface : bcd_countdown_editor_if
//  User buttons, tick and display outputs of the countdown editor.
//  Revision  : 1.0 - initial release
// ============================================================================
interface bcd_countdown_editor_if #(
  parameter int NFIELDS = 3,
  parameter int CW      = $clog2(2*NFIELDS)
);
  logic                 i_en;
  logic                 i_bt_up;
  logic                 i_bt_down;
  logic                 i_bt_left;
  logic                 i_bt_right;
  logic                 i_start;
  logic                 i_tick;
  logic [8*NFIELDS-1:0] o_value;
  logic [CW-1:0]        o_cursor;
  logic                 o_running;
  logic                 o_expired;

  modport master (
    output i_en, i_bt_up, i_bt_down, i_bt_left, i_bt_right, i_start, i_tick,
    input  o_value, o_cursor, o_running, o_expired
  );

  modport slave (
    input  i_en, i_bt_up, i_bt_down, i_bt_left, i_bt_right, i_start, i_tick,
    output o_value, o_cursor, o_running, o_expired
  );
endinterface
`default_nettype wire

// File: rtl/bcd_countdown_editor_field.sv
`default_nettype none
// ============================================================================
//  Module  : bcd_field
//  One two-digit BCD field: range-correct digit editing and countdown with
//  borrow chaining to the next more significant field.
//  Revision: 1.0 - initial release
// ============================================================================
module bcd_field
  import bcd_time_pkg::*;
#(
  parameter int MAX = 59
) (
  input  wire logic       clk,
  input  wire logic       reset,
  input  wire logic       i_edit,    // this field is the edit target
  input  wire logic       i_units,   // 1: units digit, 0: tens digit
  input  wire logic       i_inc,
  input  wire logic       i_dec,
  input  wire logic       i_clamp,   // pull units down when a tens edit overshoots
  input  wire logic       i_bin,     // decrement request / borrow in
  output logic            o_borrow,  // this field underflows on i_bin
  output logic [7:0]      o_val
);
  localparam logic [3:0] MAX_T = 4'(MAX / 10);
  localparam logic [3:0] MAX_U = 4'(MAX % 10);

  logic [3:0] r_tens, r_units;
  logic [3:0] w_tens_ed, w_units_ed, w_tens_dn, w_units_dn, w_ulim;
  logic       w_do_edit;

  assign w_do_edit = i_edit && (i_inc ^ i_dec);
  assign o_borrow  = i_bin && (r_tens == 4'd0) && (r_units == 4'd0);
  assign o_val     = {r_tens, r_units};

  // Edited digit values, with the units limit tightening when tens is at max.
  always_comb begin
    w_tens_ed  = r_tens;
    w_units_ed = r_units;
    w_ulim     = (r_tens == MAX_T) ? MAX_U : 4'd9;
    if (!i_units) begin
      w_tens_ed = i_inc ? bcd_inc(r_tens, MAX_T) : bcd_dec(r_tens, MAX_T);
      if (i_clamp && (w_tens_ed == MAX_T) && (r_units > MAX_U))
        w_units_ed = MAX_U;
    end else begin
      w_units_ed = i_inc ? bcd_inc(r_units, w_ulim) : bcd_dec(r_units, w_ulim);
    end
  end

  // One-step countdown; 00 wraps to the field max and borrows upward.
  always_comb begin
    w_tens_dn  = r_tens;
    w_units_dn = r_units - 4'd1;
    if (r_units == 4'd0) begin
      if (r_tens == 4'd0) begin
        w_tens_dn  = MAX_T;
        w_units_dn = MAX_U;
      end else begin
        w_tens_dn  = r_tens - 4'd1;
        w_units_dn = 4'd9;
      end
    end
  end

  // Digit storage: edits and countdown never coincide (IDLE vs RUN).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tens  <= 4'd0;
      r_units <= 4'd0;
    end else if (w_do_edit) begin
      r_tens  <= w_tens_ed;
      r_units <= w_units_ed;
    end else if (i_bin) begin
      r_tens  <= w_tens_dn;
      r_units <= w_units_dn;
    end
  end
endmodule
`default_nettype wire

// File: rtl/bcd_countdown_editor.sv
`default_nettype none
// ============================================================================
//  Module  : bcd_countdown_editor
//  Cursor/up/down BCD time editor with a 1 Hz countdown run mode and a
//  sticky expiry flag.
//  Revision: 1.0 - initial release
// ============================================================================
module bcd_countdown_editor
  import bcd_time_pkg::*;
#(
  parameter int NFIELDS = 3,
  parameter int TOP_MAX = 23,
  parameter int CW      = $clog2(2*NFIELDS)
) (
  input wire logic               clk,
  input wire logic               reset,
  bcd_countdown_editor_if.slave  bus
);
  localparam logic [CW-1:0]        CUR_MAX  = CW'(2*NFIELDS - 1);
  localparam logic [8*NFIELDS-1:0] ONE_SEC  = {{(8*NFIELDS-1){1'b0}}, 1'b1};

  logic r_up_q, r_down_q, r_left_q, r_right_q, r_start_q;
  logic w_up_e, w_down_e, w_left_e, w_right_e, w_start_e;

  mode_t                r_state, w_state_nxt;
  logic [CW-1:0]        r_cursor, w_fsel;
  logic                 r_expired;
  logic [8*NFIELDS-1:0] w_value;
  logic [NFIELDS:0]     w_bin;
  logic                 w_idle_en, w_digit_edit, w_go, w_pause, w_dec, w_zero, w_end;

  assign w_up_e    = bus.i_bt_up    & ~r_up_q;
  assign w_down_e  = bus.i_bt_down  & ~r_down_q;
  assign w_left_e  = bus.i_bt_left  & ~r_left_q;
  assign w_right_e = bus.i_bt_right & ~r_right_q;
  assign w_start_e = bus.i_start    & ~r_start_q;

  assign w_idle_en    = bus.i_en && (r_state == ST_IDLE);
  assign w_digit_edit = w_idle_en && (w_up_e ^ w_down_e);
  assign w_zero       = (w_value == '0);
  assign w_go         = w_idle_en && w_start_e && !w_zero;
  assign w_pause      = bus.i_en && (r_state == ST_RUN) && w_start_e;
  assign w_dec        = bus.i_en && (r_state == ST_RUN) && bus.i_tick && !w_start_e;
  // A full underflow could only start from all-zero; it also ends the run.
  assign w_end        = (w_value == ONE_SEC) || w_bin[NFIELDS];

  // Cursor 0 is the top field; two cursor positions per field.
  assign w_fsel = CW'(NFIELDS - 1) - (r_cursor >> 1);

  // Edge-detect copies follow the inputs every cycle, even when disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_up_q    <= 1'b0;
      r_down_q  <= 1'b0;
      r_left_q  <= 1'b0;
      r_right_q <= 1'b0;
      r_start_q <= 1'b0;
    end else begin
      r_up_q    <= bus.i_bt_up;
      r_down_q  <= bus.i_bt_down;
      r_left_q  <= bus.i_bt_left;
      r_right_q <= bus.i_bt_right;
      r_start_q <= bus.i_start;
    end
  end

  // Mode register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Mode transitions: start toggles, reaching zero ends the run, disable idles.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_go) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_pause || (w_dec && w_end)) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (!bus.i_en) w_state_nxt = ST_IDLE;
  end

  // Cursor moves only while editing; simultaneous left/right cancels.
  always_ff @(posedge clk) begin
    if (reset || !bus.i_en) begin
      r_cursor <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_right_e && !w_left_e)
        r_cursor <= (r_cursor == CUR_MAX) ? '0 : r_cursor + CW'(1);
      else if (w_left_e && !w_right_e)
        r_cursor <= (r_cursor == '0) ? CUR_MAX : r_cursor - CW'(1);
    end
  end

  // Sticky expiry: set on the final decrement, cleared by a new run or an edit.
  always_ff @(posedge clk) begin
    if (reset)                      r_expired <= 1'b0;
    else if (w_dec && w_end)        r_expired <= 1'b1;
    else if (w_go || w_digit_edit)  r_expired <= 1'b0;
  end

  assign w_bin[0] = w_dec;

  for (genvar k = 0; k < NFIELDS; k++) begin : g_field
    bcd_field #(
      .MAX (field_max(k, NFIELDS, TOP_MAX))
    ) u_field (
      .clk      (clk),
      .reset    (reset),
      .i_edit   (w_digit_edit && (w_fsel == CW'(k))),
      .i_units  (r_cursor[0]),
      .i_inc    (w_up_e),
      .i_dec    (w_down_e),
      .i_clamp  (1'b1),
      .i_bin    (w_bin[k]),
      .o_borrow (w_bin[k+1]),
      .o_val    (w_value[8*k +: 8])
    );
  end

  assign bus.o_value   = w_value;
  assign bus.o_cursor  = r_cursor;
  assign bus.o_running = (r_state == ST_RUN);
  assign bus.o_expired = r_expired;
endmodule
`default_nettype wire

// File: tb/tb_bcd_countdown_editor.sv
`default_nettype none
// ============================================================================
//  Module  : tb_bcd_countdown_editor
//  Directed self-checking bench for bcd_countdown_editor (NFIELDS=3, TOP_MAX=23).
//  Revision: 1.0 - initial release
// ============================================================================
module tb_bcd_countdown_editor;
  localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3, B_START = 4;

  logic clk;
  logic reset;
  int   errs = 0;
  int   nchk = 0;

  bcd_countdown_editor_if #(.NFIELDS(3)) bus ();

  bcd_countdown_editor #(.NFIELDS(3), .TOP_MAX(23)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      B_UP:    bus.i_bt_up    = v;
      B_DOWN:  bus.i_bt_down  = v;
      B_LEFT:  bus.i_bt_left  = v;
      B_RIGHT: bus.i_bt_right = v;
      default: bus.i_start    = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    cyc();
    set_btn(b, 1'b0);
    cyc();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    bus.i_en = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    nchk++; if (bus.o_value !== 24'h000000) begin errs++; $display("FAIL reset_value: got %h expected %h", bus.o_value, 24'h0); end
    nchk++; if (bus.o_cursor !== 3'd0) begin errs++; $display("FAIL reset_cursor: got %0d expected 0", bus.o_cursor); end
    nchk++; if (bus.o_running !== 1'b0) begin errs++; $display("FAIL reset_running: got %b expected 0", bus.o_running); end
    nchk++; if (bus.o_expired !== 1'b0) begin errs++; $display("FAIL reset_expired: got %b expected 0", bus.o_expired); end
    reset = 1'b0;
    bus.i_en = 1'b1;
    cyc();
  endtask

  task automatic test_cursor();
    for (int i = 0; i < 7; i++) press(B_RIGHT);
    nchk++; if (bus.o_cursor !== 3'd1) begin errs++; $display("FAIL cursor_right_wrap: got %0d expected 1", bus.o_cursor); end
    press(B_LEFT);
    press(B_LEFT);
    nchk++; if (bus.o_cursor !== 3'd5) begin errs++; $display("FAIL cursor_left_wrap: got %0d expected 5", bus.o_cursor); end
    bus.i_bt_left = 1'b1; bus.i_bt_right = 1'b1;
    cyc();
    nchk++; if (bus.o_cursor !== 3'd5) begin errs++; $display("FAIL cursor_left_right: got %0d expected 5", bus.o_cursor); end
    bus.i_bt_left = 1'b0; bus.i_bt_right = 1'b0;
    cyc();
    press(B_RIGHT);
    nchk++; if (bus.o_cursor !== 3'd0) begin errs++; $display("FAIL cursor_back0: got %0d expected 0", bus.o_cursor); end
  endtask

  task automatic test_tens_edit();
    logic [7:0] exp_t [3];
    exp_t = '{8'h10, 8'h20, 8'h00};
    for (int i = 0; i < 3; i++) begin
      press(B_UP);
      nchk++; if (bus.o_value[23:16] !== exp_t[i]) begin errs++; $display("FAIL top_tens_up%0d: got %h expected %h", i, bus.o_value[23:16], exp_t[i]); end
    end
    press(B_UP);
    press(B_RIGHT);
    for (int i = 0; i < 9; i++) press(B_UP);
    nchk++; if (bus.o_value !== 24'h190000) begin errs++; $display("FAIL top_19: got %h expected %h", bus.o_value, 24'h190000); end
    press(B_LEFT);
    press(B_UP);
    nchk++; if (bus.o_value !== 24'h230000) begin errs++; $display("FAIL top_clamp23: got %h expected %h", bus.o_value, 24'h230000); end
  endtask

  task automatic test_units_wrap();
    do_reset();
    for (int i = 0; i < 4; i++) press(B_RIGHT);
    for (int i = 0; i < 5; i++) press(B_UP);
    press(B_RIGHT);
    for (int i = 0; i < 9; i++) press(B_UP);
    nchk++; if (bus.o_value !== 24'h000059) begin errs++; $display("FAIL sec_59: got %h expected %h", bus.o_value, 24'h000059); end
    press(B_UP);
    nchk++; if (bus.o_value !== 24'h000050) begin errs++; $display("FAIL sec_units_wrap: got %h expected %h", bus.o_value, 24'h000050); end
    for (int i = 0; i < 3; i++) press(B_LEFT);
    press(B_DOWN);
    nchk++; if (bus.o_value !== 24'h005050) begin errs++; $display("FAIL min_tens_down_wrap: got %h expected %h", bus.o_value, 24'h005050); end
  endtask

  task automatic test_countdown();
    do_reset();
    for (int i = 0; i < 3; i++) press(B_RIGHT);
    press(B_UP);
    nchk++; if (bus.o_value !== 24'h000100) begin errs++; $display("FAIL load_0100: got %h expected %h", bus.o_value, 24'h000100); end
    bus.i_start = 1'b1;
    cyc();
    nchk++; if (bus.o_running !== 1'b1) begin errs++; $display("FAIL start_run: got %b expected 1", bus.o_running); end
    bus.i_start = 1'b0;
    cyc();
    bus.i_tick = 1'b1; cyc(); bus.i_tick = 1'b0;
    nchk++; if (bus.o_value !== 24'h000059) begin errs++; $display("FAIL tick_borrow_min: got %h expected %h", bus.o_value, 24'h000059); end
    cyc();
    for (int i = 0; i < 58; i++) begin
      bus.i_tick = 1'b1; cyc(); bus.i_tick = 1'b0; cyc();
    end
    nchk++; if (bus.o_value !== 24'h000001 || bus.o_running !== 1'b1) begin errs++; $display("FAIL at_one: got %h run %b expected %h run 1", bus.o_value, bus.o_running, 24'h000001); end
    bus.i_tick = 1'b1; cyc(); bus.i_tick = 1'b0;
    nchk++; if (bus.o_value !== 24'h000000) begin errs++; $display("FAIL expire_value: got %h expected %h", bus.o_value, 24'h0); end
    nchk++; if (bus.o_running !== 1'b0) begin errs++; $display("FAIL expire_running: got %b expected 0", bus.o_running); end
    nchk++; if (bus.o_expired !== 1'b1) begin errs++; $display("FAIL expire_flag: got %b expected 1", bus.o_expired); end
    cyc();
  endtask

  task automatic test_start_zero();
    press(B_START);
    nchk++; if (bus.o_running !== 1'b0) begin errs++; $display("FAIL start_zero_ignored: got %b expected 0", bus.o_running); end
    nchk++; if (bus.o_expired !== 1'b1) begin errs++; $display("FAIL start_zero_expired: got %b expected 1", bus.o_expired); end
    bus.i_bt_up = 1'b1; bus.i_bt_down = 1'b1;
    cyc();
    nchk++; if (bus.o_value !== 24'h000000) begin errs++; $display("FAIL up_down_together: got %h expected %h", bus.o_value, 24'h0); end
    bus.i_bt_up = 1'b0; bus.i_bt_down = 1'b0;
    cyc();
    press(B_UP);
    nchk++; if (bus.o_value !== 24'h000100) begin errs++; $display("FAIL edit_after_expire: got %h expected %h", bus.o_value, 24'h000100); end
    nchk++; if (bus.o_expired !== 1'b0) begin errs++; $display("FAIL edit_clears_expired: got %b expected 0", bus.o_expired); end
  endtask

  task automatic test_borrow_and_same_cycle();
    do_reset();
    press(B_RIGHT);
    press(B_UP);
    press(B_START);
    bus.i_tick = 1'b1; cyc(); bus.i_tick = 1'b0;
    nchk++; if (bus.o_value !== 24'h005959) begin errs++; $display("FAIL borrow_chain: got %h expected %h", bus.o_value, 24'h005959); end
    cyc();
    bus.i_start = 1'b1; bus.i_tick = 1'b1;
    cyc();
    nchk++; if (bus.o_running !== 1'b0 || bus.o_value !== 24'h005959) begin errs++; $display("FAIL run_start_tick: got run %b val %h expected run 0 val %h", bus.o_running, bus.o_value, 24'h005959); end
    bus.i_start = 1'b0; bus.i_tick = 1'b0;
    cyc();
    bus.i_start = 1'b1; bus.i_tick = 1'b1;
    cyc();
    nchk++; if (bus.o_running !== 1'b1 || bus.o_value !== 24'h005959) begin errs++; $display("FAIL idle_start_tick: got run %b val %h expected run 1 val %h", bus.o_running, bus.o_value, 24'h005959); end
    bus.i_start = 1'b0; bus.i_tick = 1'b0;
    cyc();
  endtask

  task automatic test_en_drop_and_reset();
    bus.i_tick = 1'b1; cyc(); bus.i_tick = 1'b0;
    nchk++; if (bus.o_value !== 24'h005958) begin errs++; $display("FAIL resume_tick: got %h expected %h", bus.o_value, 24'h005958); end
    bus.i_en = 1'b0; bus.i_tick = 1'b1;
    cyc();
    bus.i_tick = 1'b0;
    nchk++; if (bus.o_running !== 1'b0) begin errs++; $display("FAIL en_drop_running: got %b expected 0", bus.o_running); end
    nchk++; if (bus.o_value !== 24'h005958) begin errs++; $display("FAIL en_drop_value: got %h expected %h", bus.o_value, 24'h005958); end
    nchk++; if (bus.o_cursor !== 3'd0) begin errs++; $display("FAIL en_drop_cursor: got %0d expected 0", bus.o_cursor); end
    cyc();
    bus.i_en = 1'b1;
    press(B_START);
    nchk++; if (bus.o_running !== 1'b1) begin errs++; $display("FAIL restart: got %b expected 1", bus.o_running); end
    reset = 1'b1; bus.i_tick = 1'b1;
    cyc();
    bus.i_tick = 1'b0;
    nchk++; if (bus.o_value !== 24'h0 || bus.o_running !== 1'b0 || bus.o_cursor !== 3'd0 || bus.o_expired !== 1'b0) begin
      errs++; $display("FAIL midrun_reset: got val %h run %b cur %0d exp %b expected all 0", bus.o_value, bus.o_running, bus.o_cursor, bus.o_expired);
    end
    reset = 1'b0;
    cyc();
  endtask

  initial begin
    reset          = 1'b1;
    bus.i_en       = 1'b0;
    bus.i_bt_up    = 1'b0;
    bus.i_bt_down  = 1'b0;
    bus.i_bt_left  = 1'b0;
    bus.i_bt_right = 1'b0;
    bus.i_start    = 1'b0;
    bus.i_tick     = 1'b0;
    test_reset();
    test_cursor();
    test_tens_edit();
    test_units_wrap();
    test_countdown();
    test_start_zero();
    test_borrow_and_same_cycle();
    test_en_drop_and_reset();
    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
`default_nettype wire
